// File: rtl/mar_prog_pkg.sv
// Shared types for the programmable memory address register.
package mar_prog_pkg;

  // Front-panel step handler states
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_WAIT_REL = 2'd2
  } step_state_e;

endpackage

// File: rtl/mar_prog_step_debounce.sv
// Step button handler: synchroniser, rising-edge detect, lockout FSM.
// Emits a single-cycle fire strobe per accepted press while en is high.
module step_debounce
  import mar_prog_pkg::*;
#(
  parameter int HOLD_CYC = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic en,
  input  logic step,
  output logic fire,
  output logic busy
);

  localparam int CNT_W = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYC - 1);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic rise;

  step_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser chain runs regardless of mode so a held button never looks like a fresh press
  always_comb begin
    s1_d = step;
    s2_d = s1_q;
    s3_d = s2_q;
    rise = s2_q & ~s3_q;
  end

  // Register synchroniser, FSM state and hold counter
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and fire strobe; leaving program mode abandons any lockout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            fire    = 1'b1;
            state_d = S_HOLD;
            cnt_d   = '0;
          end
        end
        S_HOLD: begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_WAIT_REL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_REL: begin
          if (!s2_q) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: rtl/mar_prog.sv
// Parametrised memory address register with run-mode bus load and
// program-mode step load / auto-increment.
module mar_prog
  import mar_prog_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 16,
  parameter int RESET_ADDR = 0,
  parameter int HOLD_CYC   = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              prog,
  input  logic              ld_n,
  input  logic [ADDR_W-1:0] bus_in,
  input  logic [ADDR_W-1:0] sw_in,
  input  logic              inc_en,
  input  logic              step,
  output logic [ADDR_W-1:0] mar_out,
  output logic              wrap,
  output logic              addr_err,
  output logic              step_ack,
  output logic              busy
);

  // One extra bit so DEPTH = 2^ADDR_W is representable
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic fire;

  logic [ADDR_W-1:0] mar_q, mar_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic              ack_q, ack_d;

  logic              load_req;
  logic [ADDR_W-1:0] load_val;
  logic [ADDR_W:0]   inc_sum;

  step_debounce #(
    .HOLD_CYC(HOLD_CYC)
  ) u_step (
    .clk  (clk),
    .clr_n(clr_n),
    .en   (prog),
    .step (step),
    .fire (fire),
    .busy (busy)
  );

  // Mode mux, range check and increment/wrap; both load sources share one range check
  always_comb begin
    mar_d    = mar_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    ack_d    = fire;
    load_req = 1'b0;
    load_val = bus_in;
    inc_sum  = {1'b0, mar_q} + (ADDR_W + 1)'(1);
    if (!prog) begin
      load_req = !ld_n;
      load_val = bus_in;
    end else if (fire) begin
      if (inc_en) begin
        if (inc_sum >= DEPTH_X) begin
          mar_d  = '0;
          wrap_d = 1'b1;
        end else begin
          mar_d = inc_sum[ADDR_W-1:0];
        end
      end else begin
        load_req = 1'b1;
        load_val = sw_in;
      end
    end
    if (load_req) begin
      if ({1'b0, load_val} >= DEPTH_X) err_d = 1'b1;
      else                             mar_d = load_val;
    end
  end

  // Address register and single-cycle status pulses
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      mar_q  <= ADDR_W'(RESET_ADDR);
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      mar_q  <= mar_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
      ack_q  <= ack_d;
    end
  end

  assign mar_out  = mar_q;
  assign wrap     = wrap_q;
  assign addr_err = err_q;
  assign step_ack = ack_q;

endmodule

// File: tb/tb_mar_prog.sv
// Self-checking bench for mar_prog (ADDR_W=4, DEPTH=12, HOLD_CYC=4).
module tb_mar_prog;

  localparam int AW  = 4;
  localparam int DEP = 12;
  localparam int RST = 0;
  localparam int HC  = 4;

  logic          clk = 1'b0;
  logic          clr_n, prog, ld_n, inc_en, step;
  logic [AW-1:0] bus_in, sw_in, mar_out;
  logic          wrap, addr_err, step_ack, busy;

  int checks = 0;
  int errors = 0;
  int n_wrap = 0, n_err = 0, n_ack = 0;
  int e_wrap, e_err, e_ack;
  int exp_mar;

  mar_prog #(
    .ADDR_W    (AW),
    .DEPTH     (DEP),
    .RESET_ADDR(RST),
    .HOLD_CYC  (HC)
  ) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .prog    (prog),
    .ld_n    (ld_n),
    .bus_in  (bus_in),
    .sw_in   (sw_in),
    .inc_en  (inc_en),
    .step    (step),
    .mar_out (mar_out),
    .wrap    (wrap),
    .addr_err(addr_err),
    .step_ack(step_ack),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts high cycles, so a stretched pulse shows up as an extra count
  always @(negedge clk) begin
    if (wrap === 1'b1)     n_wrap = n_wrap + 1;
    if (addr_err === 1'b1) n_err  = n_err + 1;
    if (step_ack === 1'b1) n_ack  = n_ack + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired: checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cnt;
    n_wrap = 0; n_err = 0; n_ack = 0;
    e_wrap = 0; e_err = 0; e_ack = 0;
  endtask

  // Reference rules
  task automatic model_load(input int v);
    if (v < DEP) exp_mar = v;
    else         e_err   = e_err + 1;
  endtask

  task automatic model_step(input bit inc, input int sw);
    e_ack = e_ack + 1;
    if (inc) begin
      if (exp_mar == DEP - 1) begin
        exp_mar = 0;
        e_wrap  = e_wrap + 1;
      end else begin
        exp_mar = exp_mar + 1;
      end
    end else begin
      model_load(sw);
    end
  endtask

  // Stimulus: one run-mode load strobe
  task automatic do_load(input int v);
    prog   = 1'b0;
    ld_n   = 1'b0;
    bus_in = AW'(v);
    tick();
    ld_n = 1'b1;
    tick();
    tick();
  endtask

  // Stimulus: clean press of hi cycles then release; waits for lockout to end
  task automatic do_press(input int hi, output bit ok);
    step = 1'b1;
    for (int i = 0; i < hi; i++) tick();
    step = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 60 && busy === 1'b1; i++) tick();
    tick();
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset;
    clr_n = 1'b0; prog = 1'b0; ld_n = 1'b0; bus_in = AW'(5);
    sw_in = '0; inc_en = 1'b0; step = 1'b0;
    tick(); tick();
    checks++;
    if (mar_out !== AW'(RST)) begin errors++; $display("FAIL reset_mar got=%0d exp=%0d", mar_out, RST); end
    checks++;
    if ({wrap, addr_err, step_ack, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses got=%b exp=0000", {wrap, addr_err, step_ack, busy});
    end
    clr_n = 1'b1; bus_in = AW'(9);
    tick();
    ld_n = 1'b1;
    exp_mar = 9;
    checks++;
    if (mar_out !== AW'(exp_mar)) begin errors++; $display("FAIL reset_first_load got=%0d exp=%0d", mar_out, exp_mar); end
    tick();
  endtask

  task automatic test_range;
    bit ok;
    clear_cnt();
    do_load(13); model_load(13);
    checks++;
    if (mar_out !== AW'(exp_mar)) begin errors++; $display("FAIL range_run_mar got=%0d exp=%0d", mar_out, exp_mar); end
    checks++;
    if (n_err !== 1) begin errors++; $display("FAIL range_run_err got=%0d exp=1", n_err); end
    prog = 1'b1; inc_en = 1'b0; sw_in = AW'(12);
    tick();
    do_press(1, ok); model_step(1'b0, 12);
    checks++;
    if (!ok) begin errors++; $display("FAIL range_prog_timeout busy=%b exp=0", busy); end
    checks++;
    if (mar_out !== AW'(exp_mar) || n_err !== 2 || n_ack !== 1) begin
      errors++; $display("FAIL range_prog got mar=%0d err=%0d ack=%0d exp mar=%0d err=2 ack=1", mar_out, n_err, n_ack, exp_mar);
    end
    sw_in = AW'(7);
    do_press(2, ok); model_step(1'b0, 7);
    checks++;
    if (mar_out !== AW'(exp_mar) || n_err !== 2) begin
      errors++; $display("FAIL range_prog_valid got mar=%0d err=%0d exp mar=%0d err=2", mar_out, n_err, exp_mar);
    end
  endtask

  task automatic test_inc_wrap;
    bit ok1, ok2;
    do_load(10); model_load(10);
    clear_cnt();
    prog = 1'b1; inc_en = 1'b1;
    tick();
    do_press(2, ok1); model_step(1'b1, 0);
    checks++;
    if (mar_out !== AW'(exp_mar)) begin errors++; $display("FAIL inc_first got=%0d exp=%0d", mar_out, exp_mar); end
    do_press(2, ok2); model_step(1'b1, 0);
    checks++;
    if (mar_out !== AW'(exp_mar)) begin errors++; $display("FAIL inc_wrap got=%0d exp=%0d", mar_out, exp_mar); end
    checks++;
    if (n_wrap !== e_wrap || n_ack !== e_ack || !ok1 || !ok2) begin
      errors++; $display("FAIL inc_pulses got wrap=%0d ack=%0d exp wrap=%0d ack=%0d", n_wrap, n_ack, e_wrap, e_ack);
    end
  endtask

  task automatic test_bounce;
    clear_cnt();
    prog = 1'b1; inc_en = 1'b1;
    step = 1'b1; tick();
    step = 1'b0; tick();
    step = 1'b1; tick();
    for (int i = 0; i < 20; i++) tick();
    model_step(1'b1, 0);
    checks++;
    if (busy !== 1'b1 || n_ack !== 1 || mar_out !== AW'(exp_mar)) begin
      errors++; $display("FAIL bounce_held got busy=%b ack=%0d mar=%0d exp busy=1 ack=1 mar=%0d", busy, n_ack, mar_out, exp_mar);
    end
    step = 1'b0;
    tick(); tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bounce_wait_rel got busy=%b exp=1", busy); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bounce_release got busy=%b exp=0", busy); end
    tick(); tick();
    checks++;
    if (n_ack !== 1 || mar_out !== AW'(exp_mar)) begin
      errors++; $display("FAIL bounce_count got ack=%0d mar=%0d exp ack=1 mar=%0d", n_ack, mar_out, exp_mar);
    end
  endtask

  task automatic test_held_entry;
    bit ok;
    clear_cnt();
    prog = 1'b0; step = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    prog = 1'b1; inc_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (n_ack !== 0 || busy !== 1'b0 || mar_out !== AW'(exp_mar)) begin
      errors++; $display("FAIL held_entry got ack=%0d busy=%b mar=%0d exp ack=0 busy=0 mar=%0d", n_ack, busy, mar_out, exp_mar);
    end
    step = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    do_press(2, ok); model_step(1'b1, 0);
    checks++;
    if (!ok || n_ack !== 1 || mar_out !== AW'(exp_mar)) begin
      errors++; $display("FAIL held_repress got ack=%0d mar=%0d exp ack=1 mar=%0d", n_ack, mar_out, exp_mar);
    end
  endtask

  task automatic test_abort;
    do_load(6); model_load(6);
    clear_cnt();
    prog = 1'b1; inc_en = 1'b1;
    tick();
    step = 1'b1;
    for (int i = 0; i < 10 && busy !== 1'b1; i++) tick();
    model_step(1'b1, 0);
    checks++;
    if (busy !== 1'b1 || mar_out !== AW'(exp_mar)) begin
      errors++; $display("FAIL abort_enter got busy=%b mar=%0d exp busy=1 mar=%0d", busy, mar_out, exp_mar);
    end
    prog = 1'b0; ld_n = 1'b0; bus_in = AW'(3);
    tick();
    ld_n = 1'b1;
    model_load(3);
    checks++;
    if (busy !== 1'b0 || mar_out !== AW'(exp_mar)) begin
      errors++; $display("FAIL abort_drop got busy=%b mar=%0d exp busy=0 mar=%0d", busy, mar_out, exp_mar);
    end
    step = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (n_ack !== 1 || mar_out !== AW'(exp_mar)) begin
      errors++; $display("FAIL abort_after got ack=%0d mar=%0d exp ack=1 mar=%0d", n_ack, mar_out, exp_mar);
    end
  endtask

  task automatic test_random;
    bit ok;
    int v, sw, hi;
    bit inc;
    clear_cnt();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        v    = int'($urandom_range(0, 15));
        step = 1'($urandom_range(0, 1));
        do_load(v);
        step = 1'b0;
        tick(); tick(); tick();
        model_load(v);
      end else begin
        inc    = 1'($urandom_range(0, 1));
        sw     = int'($urandom_range(0, 15));
        hi     = int'($urandom_range(1, 5));
        prog   = 1'b1;
        inc_en = inc;
        sw_in  = AW'(sw);
        ld_n   = 1'($urandom_range(0, 1));
        bus_in = AW'($urandom_range(0, 15));
        tick();
        do_press(hi, ok);
        ld_n = 1'b1;
        model_step(inc, sw);
        checks++;
        if (!ok) begin errors++; $display("FAIL rand_timeout iter=%0d busy=%b exp=0", i, busy); end
      end
      checks++;
      if (mar_out !== AW'(exp_mar)) begin
        errors++; $display("FAIL rand_mar iter=%0d got=%0d exp=%0d", i, mar_out, exp_mar);
      end
    end
    tick();
    checks++;
    if (n_wrap !== e_wrap || n_err !== e_err || n_ack !== e_ack) begin
      errors++; $display("FAIL rand_pulses got wrap=%0d err=%0d ack=%0d exp wrap=%0d err=%0d ack=%0d",
                         n_wrap, n_err, n_ack, e_wrap, e_err, e_ack);
    end
  endtask

  initial begin
    test_reset();
    test_range();
    test_inc_wrap();
    test_bounce();
    test_held_entry();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
